// File: rtl/uart_tx_pkg.sv
// ============================================================================
// Module      : uart_tx_pkg
// Description : Shared UART definitions: FSM state encodings, parity types,
//               default data width. Common to the TX and RX paths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_tx_pkg;

    localparam int C_DATA_WIDTH = 8;

    localparam logic C_PAR_EVEN = 1'b0;
    localparam logic C_PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_baud_counter.sv
// ============================================================================
// Module      : uart_tx_baud_counter
// Description : Per-bit cycle counter (edge_cnt) and data-bit index (bit_cnt)
//               for the UART transmitter, driven by the TX FSM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_baud_counter
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear,
    input  logic       bit_inc,
    input  logic [5:0] prescale,
    output logic       bit_done,
    output logic       last_bit
);

    localparam logic [3:0] C_LAST_BIT = 4'(DATA_WIDTH - 1);

    logic [5:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;

    assign bit_done = (r_edge_cnt == (prescale - 6'd1));
    assign last_bit = (r_bit_cnt == C_LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (enable) begin
            r_edge_cnt <= bit_done ? 6'd0 : r_edge_cnt + 6'd1;
            // Bit index wraps back to 0 as DATA is left, ready for the next frame
            if (bit_inc && bit_done) begin
                r_bit_cnt <= last_bit ? 4'd0 : r_bit_cnt + 4'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter: start, DATA_WIDTH data bits LSB first,
//               optional parity, stop. Define UART_TX_TWO_STOP_EN for two
//               stop bits.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = C_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic                  TX_OUT,
    output logic                  Busy
);

    tx_state_t             r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_parity;
    logic [5:0]            r_prescale;
    logic                  r_tx;
    logic                  r_busy;
`ifdef UART_TX_TWO_STOP_EN
    logic                  r_stop_second;
`endif

    logic [5:0]            w_prescale_eff;
    logic                  w_parity;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic                  w_bit_done;
    logic                  w_last_bit;

    assign w_prescale_eff = (Prescale == 6'd0) ? 6'd1 : Prescale;
    assign w_parity       = (PAR_TYP == C_PAR_ODD) ? ~^P_DATA : ^P_DATA;
    assign w_shift_next   = r_shift >> 1;

    uart_tx_baud_counter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_baud_counter (
        .clk      (clk),
        .rst      (rst),
        .enable   (r_state != ST_IDLE),
        .clear    (r_state == ST_IDLE),
        .bit_inc  (r_state == ST_DATA),
        .prescale (r_prescale),
        .bit_done (w_bit_done),
        .last_bit (w_last_bit)
    );

    // TX_OUT is loaded with the value of the state being entered, so the line
    // changes exactly on the edge that starts each bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_parity   <= 1'b0;
            r_prescale <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
`ifdef UART_TX_TWO_STOP_EN
            r_stop_second <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (Data_Valid) begin
                        r_shift    <= P_DATA;
                        r_par_en   <= PAR_EN;
                        r_parity   <= w_parity;
                        r_prescale <= w_prescale_eff;
                        r_state    <= ST_START;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_START: begin
                    if (w_bit_done) begin
                        r_state <= ST_DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_bit_done) begin
                        if (w_last_bit) begin
                            if (r_par_en) begin
                                r_state <= ST_PARITY;
                                r_tx    <= r_parity;
                            end else begin
                                r_state <= ST_STOP;
                                r_tx    <= 1'b1;
                            end
                        end else begin
                            r_shift <= w_shift_next;
                            r_tx    <= w_shift_next[0];
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_done) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_done) begin
`ifdef UART_TX_TWO_STOP_EN
                        if (!r_stop_second) begin
                            r_stop_second <= 1'b1;
                        end else begin
                            r_stop_second <= 1'b0;
                            r_state       <= ST_IDLE;
                            r_busy        <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                        r_tx <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign Busy   = r_busy;

endmodule

`default_nettype wire
